serial_parity_checker: RTL
==========================

Name: serial_parity_checker

Overview:
Bit-serial parity checker, the sequential successor to the combinational 4-bit odd parity checker. It receives a frame of DATA_W data bits (LSB first) plus one trailing parity bit. The frame is checked against odd or even parity, selectable at run time per frame. It reassembles the data word and reports a one-cycle done pulse with pass/fail status. It sits behind a serial-line deserialiser or bit-banged test interface in the combinational-circuits family.

Parameters:
DATA_W, 4, data bits per frame (>=1); also the width of data_out
ERR_CNT_W, 8, width of the optional error counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new frame; honoured only in IDLE
odd_mode  input  1  sampled with start: 1 = odd parity, 0 = even parity
abort  input  1  drop the current frame and return to IDLE
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial data or parity bit
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse: frame complete, results valid
data_out  output  DATA_W  reassembled data word, held until the next done
parity_ok  output  1  result of the last completed frame, held until the next done
err_cnt  output  ERR_CNT_W  saturating count of failed frames (only with ERR_CNT_EN)

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, data_out=0, parity_ok=0, err_cnt=0; internal shift register, accumulator and bit counter cleared.
- FSM states: IDLE, DATA, PARITY, REPORT.
- IDLE:
  - start=1 → latch odd_mode, clear the accumulator and bit counter, go to DATA.
  - bit_valid is ignored in IDLE.
- DATA:
  - Each cycle with bit_valid=1 → shift bit_in into the internal shift register at the MSB, shifting right, so the first bit lands in bit 0 after DATA_W shifts.
  - The same cycle: accumulator ^= bit_in, counter++.
  - When counter reaches DATA_W-1 and a bit is accepted → go to PARITY.
  - bit_valid=0 cycles are stalls: no change, no timeout.
- PARITY:
  - On bit_valid=1, total = accumulator ^ bit_in.
  - Odd mode: pass iff total==1. Even mode: pass iff total==0.
  - Go to REPORT.
- REPORT (exactly one cycle):
  - done=1; data_out and parity_ok are updated on entry to REPORT and are therefore visible with done.
  - Next state is IDLE.
- Latency: done is high the cycle after the cycle in which the parity bit is accepted. The minimum frame is DATA_W+3 cycles from start to the return to IDLE.
- busy is 1 in DATA, PARITY and REPORT.
- start outside IDLE is ignored, including in REPORT. A new frame may start the cycle after REPORT.
- abort in DATA or PARITY → IDLE next cycle. No done pulse; data_out, parity_ok and err_cnt are unchanged.
- abort has priority over a coincident bit_valid. abort in IDLE or REPORT has no effect.
- Reset mid-frame discards the frame immediately. No done pulse.
- odd_mode changes after start have no effect on the current frame.

Optional Feature:
Macro SERIAL_PARITY_ERR_CNT_EN.
- Defined: err_cnt increments on every REPORT with parity_ok=0, saturates at 2^ERR_CNT_W-1, and is cleared only by reset.
- Not defined: no counter register exists; the err_cnt port is tied to 0.

Decomposition:
- Shared package parity_pkg holds:
  - the state enum (IDLE, DATA, PARITY, REPORT) with a 2-bit encoding;
  - constants PARITY_ODD=1'b1 and PARITY_EVEN=1'b0;
  - a function that turns mode and total XOR into pass/fail.
- One natural sub-module: sat_counter, a parametrised saturating counter with increment enable, instantiated only under the macro.
- Bit counter width: $clog2(DATA_W) with a minimum of 1.

Test Plan (DATA_W=4):
- Odd mode, start, bits 1,1,0,1 (data 4'hB, three ones), parity 0 → done one cycle after the parity bit; data_out=4'hB, parity_ok=1.
- Even mode, data 4'h0, parity 1 → parity_ok=0; err_cnt=1 (macro on) or 0 (macro off).
- Odd mode, data 4'h6 sent with two idle bit_valid=0 cycles between bits, parity 1 → parity_ok=1, data_out=4'h6; done still exactly one pulse.
- After 2 data bits assert abort together with bit_valid → busy=0 next cycle, no done, data_out/parity_ok unchanged. Then start mid-abort-cycle is ignored; a start one cycle later is accepted.
- Drop rst_n during PARITY → all outputs 0 immediately. A following frame (odd, 4'hF, parity 1) gives parity_ok=1.
- ERR_CNT_W=2 with the macro on: 5 consecutive failing frames → err_cnt=1,2,3,3,3.
- Sweep all 16 data values in both modes with correct and flipped parity bits → 64 checks against the model.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM states, parity mode constants and pass/fail helper
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;

    // A frame passes when the XOR of all its bits equals the value the mode demands.
    function automatic logic parity_pass(input logic mode, input logic total);
        return total == ((mode == PARITY_ODD) ? PARITY_ODD : PARITY_EVEN);
    endfunction

endpackage

// File: rtl/serial_parity_checker_sat_counter.sv
// rtl/serial_parity_checker_sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - bit-serial odd/even parity checker; SERIAL_PARITY_ERR_CNT_EN adds a failed-frame counter
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 odd_mode,
    input  logic                 abort,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    data_out,
    output logic                 parity_ok,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e             state_q,     state_d;
    logic               odd_q,       odd_d;
    logic [DATA_W-1:0]  shreg_q,     shreg_d;
    logic               acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DATA_W-1:0]  data_out_q,  data_out_d;
    logic               parity_ok_q, parity_ok_d;
    logic               done_q,      done_d;
    logic               busy_q,      busy_d;

    always_comb begin
        state_d     = state_q;
        odd_d       = odd_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        parity_ok_d = parity_ok_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    odd_d   = odd_mode;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    // LSB-first line: each new bit enters at the top and walks down.
                    shreg_d[DATA_W-1] = bit_in;
                    for (int i = 0; i < DATA_W - 1; i++) begin
                        shreg_d[i] = shreg_q[i+1];
                    end
                    acc_d = acc_q ^ bit_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    parity_ok_d = parity_pass(odd_q, acc_q ^ bit_in);
                    data_out_d  = shreg_q;
                    done_d      = 1'b1;
                    state_d     = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            odd_q       <= 1'b0;
            shreg_q     <= '0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            parity_ok_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            odd_q       <= odd_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            parity_ok_q <= parity_ok_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign data_out  = data_out_q;
    assign parity_ok = parity_ok_q;

`ifdef SERIAL_PARITY_ERR_CNT_EN
    // Counting on entry to REPORT makes the new count visible alongside done.
    logic err_inc;
    assign err_inc = done_d & ~parity_ok_d;

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule
